// File: rtl/rv32v_element_sequencer_if.sv
// Dispatch-side request and lane-side issue bundle for the RV32V element sequencer.
interface rv32v_element_sequencer_if #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned LANES = 2
);
    localparam int unsigned VLENB = VLEN / 8;
    localparam int unsigned EW    = $clog2(VLEN);
    localparam int unsigned VLW   = EW + 1;
    localparam int unsigned BW    = $clog2(VLENB);

    logic             req_valid;
    logic             req_ready;
    logic [VLW-1:0]   req_vl;
    logic [EW-1:0]    req_vstart;
    logic [1:0]       req_vsew;
    logic [2:0]       req_vlmul;
    logic             flush;

    logic             issue_valid;
    logic             issue_ready;
    logic [EW-1:0]    issue_eidx;
    logic [LANES-1:0] issue_mask;
    logic [2:0]       issue_vreg_off;
    logic [BW-1:0]    issue_byte_off;
    logic             issue_last;
    logic             done;
    logic             error;

    // Dispatch / datapath side
    modport master (
        output req_valid, req_vl, req_vstart, req_vsew, req_vlmul, flush, issue_ready,
        input  req_ready, issue_valid, issue_eidx, issue_mask, issue_vreg_off,
               issue_byte_off, issue_last, done, error
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_vl, req_vstart, req_vsew, req_vlmul, flush, issue_ready,
        output req_ready, issue_valid, issue_eidx, issue_mask, issue_vreg_off,
               issue_byte_off, issue_last, done, error
    );
endinterface

// File: rtl/rv32v_element_sequencer.sv
// Walks one vector instruction's active element range and issues LANES-wide beats.
module rv32v_element_sequencer #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned LANES = 2
) (
    input logic                       CLK,
    input logic                       nRST,
    rv32v_element_sequencer_if.slave  bus
);
    localparam int unsigned VLENB = VLEN / 8;
    localparam int unsigned EW    = $clog2(VLEN);
    localparam int unsigned VLW   = EW + 1;
    localparam int unsigned BW    = $clog2(VLENB);
    localparam int unsigned SW    = EW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    eidx_q, eidx_d;
    logic [VLW-1:0]   vl_q, vl_n;
    logic [EW-1:0]    vstart_q, vstart_n;
    logic [1:0]       vsew_q, vsew_n;
    logic             err_q, err_n;

    logic             accept;
    logic             illegal;
    logic             empty;
    logic [VLW-1:0]   vlmax;
    logic [SW-1:0]    byte_addr;

    logic             valid_q, valid_d;
    logic [EW-1:0]    oeidx_q, oeidx_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [2:0]       vreg_q, vreg_d;
    logic [BW-1:0]    boff_q, boff_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    // Flush blocks acceptance combinationally; otherwise ready only in IDLE.
    assign bus.req_ready = (state_q == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;

    // Request classification: VLMAX = VLENB * LMUL / sew_bytes, all shifts.
    assign vlmax   = (VLW'(VLENB) << bus.req_vlmul[1:0]) >> bus.req_vsew;
    assign illegal = (bus.req_vsew == 2'b11) || bus.req_vlmul[2] || (bus.req_vl > vlmax);
    assign empty   = (bus.req_vl == '0) || (VLW'(bus.req_vstart) >= bus.req_vl);

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and element-pointer logic; flush overrides everything
    always_comb begin
        state_d  = state_q;
        eidx_d   = eidx_q;
        vl_n     = vl_q;
        vstart_n = vstart_q;
        vsew_n   = vsew_q;
        err_n    = err_q;
        if (accept) begin
            vl_n     = bus.req_vl;
            vstart_n = bus.req_vstart;
            vsew_n   = bus.req_vsew;
            err_n    = illegal;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || empty) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        eidx_d  = bus.req_vstart & ~EW'(LANES - 1);
                    end
                end
            end
            ISSUE: begin
                if (valid_q && bus.issue_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        eidx_d = eidx_q + EW'(LANES);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    // Next values of the registered beat outputs, derived from the next state
    always_comb begin
        valid_d   = 1'b0;
        oeidx_d   = '0;
        mask_d    = '0;
        vreg_d    = '0;
        boff_d    = '0;
        last_d    = 1'b0;
        done_d    = (state_d == DONE);
        error_d   = (state_d == DONE) && err_n;
        byte_addr = SW'(eidx_d) << vsew_n;
        if (state_d == ISSUE) begin
            valid_d = 1'b1;
            oeidx_d = eidx_d;
            vreg_d  = 3'(byte_addr >> BW);
            boff_d  = byte_addr[BW-1:0];
            last_d  = (VLW'(eidx_d) + VLW'(LANES)) >= vl_n;
            for (int i = 0; i < LANES; i++) begin
                mask_d[i] = ((VLW'(eidx_d) + VLW'(i)) >= VLW'(vstart_n)) &&
                            ((VLW'(eidx_d) + VLW'(i)) < vl_n);
            end
        end
    end

    // Captured request, element pointer and output registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            eidx_q   <= '0;
            vl_q     <= '0;
            vstart_q <= '0;
            vsew_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            oeidx_q  <= '0;
            mask_q   <= '0;
            vreg_q   <= '0;
            boff_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            eidx_q   <= eidx_d;
            vl_q     <= vl_n;
            vstart_q <= vstart_n;
            vsew_q   <= vsew_n;
            err_q    <= err_n;
            valid_q  <= valid_d;
            oeidx_q  <= oeidx_d;
            mask_q   <= mask_d;
            vreg_q   <= vreg_d;
            boff_q   <= boff_d;
            last_q   <= last_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.issue_valid    = valid_q;
    assign bus.issue_eidx     = oeidx_q;
    assign bus.issue_mask     = mask_q;
    assign bus.issue_vreg_off = vreg_q;
    assign bus.issue_byte_off = boff_q;
    assign bus.issue_last     = last_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
endmodule
